// File: rtl/cnnip_mem_if.sv
// Block-RAM port with the en/we/valid read protocol: the slave answers a read
// issued with en=1, we=0 by pulsing valid with dout a fixed number of cycles later.
interface cnnip_mem_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           din;
  logic [31:0]           dout;
  logic                  valid;

  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator: turns a start command into a write burst (from a valid/ready
// stream) or a read burst (onto a valid/ready stream). Read timeout: MEM_BURST_TIMEOUT_EN.
module mem_burst_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int LEN_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  cnnip_mem_if.master           mem_if
);

  localparam int WA_W = ADDR_WIDTH - 2;
  localparam logic [WA_W-1:0]      WA_ONE  = 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WA_W-1:0]      word_addr;
  logic [LEN_WIDTH-1:0] remain;
  logic                 word_step;
  logic                 cmd_accept;
  logic                 timeout_hit;
  logic                 en_c;
  logic                 we_c;
  logic [31:0]          din_c;

  // Byte-lane bits of the start address carry no meaning for word bursts.
  logic unused_addr_bits;
  assign unused_addr_bits = ^base_addr[1:0];

`ifdef MEM_BURST_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TC_W-1:0] TC_ONE  = 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYCLES - 1);
  logic [TC_W-1:0] wait_cnt;
  logic            err_q;
  assign timeout_hit = (state == RD_WAIT) && !mem_if.valid && (wait_cnt == TC_LAST);
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en_c      = 1'b0;
    we_c      = 1'b0;
    din_c     = 32'h0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) state_nxt = DONE;
          else           state_nxt = rw ? WR : RD_ISSUE;
        end
      end
      WR: begin
        wr_ready = 1'b1;
        en_c     = wr_valid;
        we_c     = 1'b1;
        din_c    = wr_data;
        if (wr_valid && (remain == LEN_ONE)) state_nxt = DONE;
      end
      RD_ISSUE: begin
        en_c      = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_if.valid)     state_nxt = RD_OUT;
        else if (timeout_hit) state_nxt = DONE;
      end
      RD_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) state_nxt = (remain == LEN_ONE) ? DONE : RD_ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign cmd_accept  = (state == IDLE) && start;
  assign word_step   = ((state == WR) && wr_valid) || ((state == RD_OUT) && rd_ready);

  assign mem_if.en   = en_c;
  assign mem_if.we   = we_c;
  assign mem_if.din  = din_c;
  assign mem_if.addr = {word_addr, 2'b00};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      word_addr <= '0;
      remain    <= '0;
      rd_data   <= 32'h0;
    end else begin
      if (cmd_accept) begin
        word_addr <= base_addr[ADDR_WIDTH-1:2];
        remain    <= len;
      end else if (word_step) begin
        word_addr <= word_addr + WA_ONE;
        if (remain != '0) remain <= remain - LEN_ONE;
      end
      if ((state == RD_WAIT) && mem_if.valid) rd_data <= mem_if.dout;
    end
  end

`ifdef MEM_BURST_TIMEOUT_EN
  // The wait counter restarts on every issue, so each word gets the full budget.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == RD_ISSUE)     wait_cnt <= '0;
      else if (state == RD_WAIT) wait_cnt <= wait_cnt + TC_ONE;
      if (cmd_accept)       err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master against a latency-3 block-RAM model,
// with directed cases followed by randomized bursts checked against a word-array model.
module tb_mem_burst_master;

  localparam int LAT   = 3;
  localparam int WORDS = 16384;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic        rw;
  logic [15:0] base_addr;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;

  cnnip_mem_if #(.ADDR_WIDTH(16)) mem ();

  mem_burst_master #(.ADDR_WIDTH(16), .LEN_WIDTH(12), .TIMEOUT_CYCLES(15)) dut (
    .clk       (clk),
    .arst      (arst),
    .start     (start),
    .rw        (rw),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .mem_if    (mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_arr [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic        silent = 1'b0;
  logic [LAT-1:0] vp = '0;
  logic [31:0] dp [LAT];

  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  logic        done_err = 1'b0;
  logic [15:0] wq_addr [$];
  logic [31:0] wq_data [$];
  int          iss_q [$];
  logic [31:0] rdq [$];

  assign mem.valid = vp[LAT-1];
  assign mem.dout  = dp[LAT-1];

  // Memory slave: fixed read latency LAT, writes land immediately.
  always @(posedge clk) begin
    if (mem.en && mem.we) mem_arr[mem.addr[15:2]] <= mem.din;
    vp    <= {vp[LAT-2:0], mem.en && !mem.we && !silent};
    dp[0] <= mem_arr[mem.addr[15:2]];
    for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
  end

  // Event recorder: every value here belongs to the cycle ending at this edge.
  always @(posedge clk) begin
    if (mem.en && mem.we) begin
      wq_addr.push_back(mem.addr);
      wq_data.push_back(mem.din);
    end
    if (mem.en && !mem.we) iss_q.push_back(cyc);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      done_err <= err;
    end
    if (start && !busy) start_cyc <= cyc;
    if (rd_valid && rd_ready) rdq.push_back(rd_data);
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [15:0] b, input int i);
    return ((int'(b) >> 2) + i) % WORDS;
  endfunction

  task automatic do_start(input logic r, input logic [15:0] b, input logic [11:0] n);
    start = 1'b1; rw = r; base_addr = b; len = n;
    step();
    start = 1'b0; rw = 1'b0; base_addr = 16'h0; len = 12'h0;
  endtask

  // mode 0: wr_valid held high; mode 1: random wr_valid. poke: stray start mid-burst.
  task automatic run_write(input string tag, input logic [15:0] b, input int n,
                           input int mode, input bit fixed, input bit poke);
    logic [31:0] d [$];
    int wq0, dc0, idx, cnt;
    bit acc;
    for (int i = 0; i < n; i++) d.push_back(fixed ? 32'hA0 + i : $urandom);
    wq0 = wq_addr.size(); dc0 = done_cnt; idx = 0; cnt = 0;
    wr_valid = 1'b0;
    do_start(1'b1, b, 12'(n));
    while (done_cnt == dc0 && cnt < 3000) begin
      if (poke && cnt == 0) begin
        start = 1'b1; rw = 1'b0; len = 12'd9; base_addr = 16'h4000;
      end else begin
        start = 1'b0;
      end
      wr_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wr_data  = (idx < n) ? d[idx] : 32'hDEADBEEF;
      acc = wr_valid && wr_ready;
      step();
      if (acc) idx++;
      cnt++;
    end
    start = 1'b0; wr_valid = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_cnt != dc0), 32'd1);
    chk({tag, "_nwrites"}, 32'(wq_addr.size() - wq0), 32'(n));
    for (int i = 0; i < n; i++) ref_mem[widx(b, i)] = d[i];
    for (int i = 0; i < n && (wq0 + i) < wq_addr.size(); i++) begin
      chk({tag, "_waddr"}, 32'(wq_addr[wq0+i]), 32'(widx(b, i) * 4));
      chk({tag, "_wdata"}, wq_data[wq0+i], d[i]);
    end
    if (mode == 0) chk({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(n + 1));
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  // mode 0: rd_ready high; mode 1: random; mode 2: ready low 3 cycles on word 1.
  task automatic run_read(input string tag, input logic [15:0] b, input int n, input int mode);
    int rq0, iq0, dc0, cnt, held;
    bit prev_hold;
    logic [31:0] prev_data;
    rq0 = rdq.size(); iq0 = iss_q.size(); dc0 = done_cnt;
    cnt = 0; held = 0; prev_hold = 0; prev_data = 32'h0;
    rd_ready = 1'b0;
    do_start(1'b0, b, 12'(n));
    while (done_cnt == dc0 && cnt < 3000) begin
      if (prev_hold) begin
        chk({tag, "_hold_vld"}, 32'(rd_valid), 32'd1);
        chk({tag, "_hold_data"}, rd_data, prev_data);
      end
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = 1'($urandom_range(0, 1));
        default: begin
          if (rd_valid && (rdq.size() - rq0) == 1 && held < 3) begin
            rd_ready = 1'b0; held++;
          end else begin
            rd_ready = 1'b1;
          end
        end
      endcase
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      step();
      cnt++;
    end
    rd_ready = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_cnt != dc0), 32'd1);
    chk({tag, "_nwords"}, 32'(rdq.size() - rq0), 32'(n));
    chk({tag, "_nissues"}, 32'(iss_q.size() - iq0), 32'(n));
    for (int i = 0; i < n && (rq0 + i) < rdq.size(); i++)
      chk({tag, "_rdata"}, rdq[rq0+i], ref_mem[widx(b, i)]);
    if (mode == 0) begin
      chk({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(5 * n + 1));
      if (n > 1 && iss_q.size() >= iq0 + 2)
        chk({tag, "_en_gap"}, 32'(iss_q[iq0+1] - iss_q[iq0]), 32'(LAT + 2));
    end
    if (mode == 2 && iss_q.size() >= iq0 + 3)
      chk({tag, "_stall_gap"}, 32'(iss_q[iq0+2] - iss_q[iq0+1]), 32'(LAT + 2 + 3));
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int dc0, iq0;
    for (int i = 0; i < WORDS; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    for (int k = 0; k < LAT; k++) dp[k] = 32'h0;
    arst = 1'b1; start = 1'b0; rw = 1'b0; base_addr = 16'h0; len = 12'h0;
    wr_data = 32'h0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("rst_ctrl", 32'({busy, done, err, wr_ready, rd_valid, mem.en, mem.we}), 32'd0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_addr", 32'(mem.addr), 32'h0);
    chk("rst_din", mem.din, 32'h0);
    step(); step();
    arst = 1'b0;
    step();

    run_write("wr4", 16'h0010, 4, 0, 1'b1, 1'b0);
    run_read("rd4", 16'h0010, 4, 0);
    run_read("rd_stall", 16'h0010, 4, 2);

    dc0 = done_cnt; iq0 = iss_q.size();
    run_write("len0_wr", 16'h0200, 0, 0, 1'b0, 1'b0);
    run_read("len0_rd", 16'h0200, 0, 0);
    chk("len0_no_en", 32'(iss_q.size() - iq0), 32'd0);

    run_write("busy_start", 16'h0100, 3, 0, 1'b0, 1'b1);
    run_write("wrap_wr", 16'hFFFC, 2, 0, 1'b0, 1'b0);
    run_read("wrap_rd", 16'hFFFC, 2, 0);

    // Asynchronous reset in the wait for word 1 of a read burst.
    dc0 = done_cnt;
    rd_ready = 1'b1;
    do_start(1'b0, 16'h0010, 4);
    repeat (6) step();
    chk("pre_arst_busy", 32'(busy), 32'd1);
    #3 arst = 1'b1;
    #1;
    chk("arst_ctrl", 32'({busy, done, err, wr_ready, rd_valid, mem.en, mem.we}), 32'd0);
    chk("arst_rd_data", rd_data, 32'h0);
    chk("arst_addr", 32'(mem.addr), 32'h0);
    chk("arst_din", mem.din, 32'h0);
    rd_ready = 1'b0;
    step();
    arst = 1'b0;
    repeat (8) step();
    chk("arst_no_done", 32'(done_cnt - dc0), 32'd0);
    run_read("post_arst_rd", 16'h0010, 4, 0);

`ifdef MEM_BURST_TIMEOUT_EN
    silent = 1'b1;
    iq0 = iss_q.size(); dc0 = done_cnt;
    do_start(1'b0, 16'h0300, 3);
    for (int c = 0; c < 200 && done_cnt == dc0; c++) step();
    silent = 1'b0;
    chk("tmo_done_seen", 32'(done_cnt != dc0), 32'd1);
    chk("tmo_nissues", 32'(iss_q.size() - iq0), 32'd1);
    if (iss_q.size() > iq0) chk("tmo_latency", 32'(done_cyc - iss_q[iq0]), 32'd16);
    chk("tmo_err_at_done", 32'(done_err), 32'd1);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    do_start(1'b1, 16'h0000, 12'd0);
    chk("tmo_err_cleared", 32'(err), 32'd0);
    step(); step();
`endif

    for (int t = 0; t < 24; t++) begin
      logic [15:0] b;
      int n, m;
      b = 16'($urandom);
      n = $urandom_range(0, 10);
      m = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) run_write("rnd_wr", b, n, m, 1'b0, 1'b0);
      else                          run_read("rnd_rd", b, n, m);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
